i2s_dac_tx: RTL and testbench
=============================

# i2s_dac_tx

- Output end of the synthesizer datapath.
- Accepts one summed voice sample per audio frame from the 16-voice adder tree: 24-bit signed Q8.16, handed over on a valid/ready handshake.
- Clips each sample to DAC full scale (signed Q1.23) and serializes it as a 24-bit-in-32-bit-slot I2S stream, driving the same word on left and right.
- Generates BCLK/LRCLK from the system clock and pulses a per-frame request that paces the voice engine.

## Interface
- CLK_DIV, 4, system clocks per BCLK half-period (≥2)
- SLOT_BITS, 32, BCLK periods per channel slot (≥25)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- sample_in  in  24  signed Q8.16 mixed sample
- sample_valid  in  1  sample_in valid
- sample_ready  out  1  holding register empty
- sample_req  out  1  one-cycle pulse at each frame boundary
- bclk  out  1  I2S bit clock
- lrclk  out  1  word select; 0 = left, 1 = right
- sdata  out  1  serial data, MSB first
- sat_flag  out  1  one-cycle pulse when the word just loaded was clipped
- underrun  out  1  one-cycle pulse when a frame boundary found no sample

## Operation
- Clock and reset are fixed: one clock, synchronous active-low reset.
- **Divider**
  - div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1, bclk toggles and div_cnt returns to 0.
- **Fall event**: the cycle where bclk toggles 1→0.
  - bit_cnt (0..2*SLOT_BITS-1) advances on each fall event, wrapping to 0.
  - The wrap cycle is the frame boundary.
- **Bit and slot mapping**
  - lrclk = (bit_cnt ≥ SLOT_BITS).
  - q = bit_cnt mod SLOT_BITS.
  - q=0 gives sdata 0 (I2S one-bit delay). q=1..24 gives word[24-q]. q=25..SLOT_BITS-1 gives 0.
  - All outputs are registered and change only on fall events, so they are stable across the bclk rising edge.
- **Holding register**
  - sample_ready = ~hold_full.
  - sample_valid & sample_ready captures sample_in and sets hold_full.
- **Frame boundary**
  - If hold_full: load the converted word, clear hold_full.
  - If not hold_full: repeat the previous word and pulse underrun.
  - Simultaneous capture at the boundary cycle bypasses straight into the word; no underrun, hold_full stays 0.
  - sample_req pulses in the boundary cycle regardless of the outcome.
- **Conversion**
  - s[23:16] all equal: word = {s[16:0], 7'b0}.
  - Otherwise saturate: s[23]=0 gives 0x7FFFFF, s[23]=1 gives 0x800000; sat_flag pulses with the load.
- **Reset**
  - Outputs: all 0, including sample_ready.
  - Internal state: counters 0, word 0, hold_full 0.
  - The first frame after reset is silence.
  - Reset mid-frame aborts the frame immediately and drops any held sample.

## Timing
- sample_ready rises the cycle after rst_n deasserts.
- It falls the cycle after a capture and rises the cycle after the boundary consumes the held sample.
- First bclk rise: CLK_DIV cycles after reset release.
- BCLK period: 2*CLK_DIV clocks.
- Frame: 4*CLK_DIV*SLOT_BITS clocks (defaults: 512 clocks; 48 kHz at 24.576 MHz).
- Latency: a sample captured in frame N is serialized in frame N+1.
  - Its MSB appears on sdata at the fall event one BCLK after the boundary.
- sat_flag, underrun and sample_req are asserted in the boundary cycle only.

## Test plan
Bench parameters: CLK_DIV=2, SLOT_BITS=32; frame = 256 clocks.
- **Reset:** rst_n low 10 cycles → all outputs 0; after release, sample_ready=1 next cycle, first bclk rise at +2 cycles, first frame sdata all 0.
- **In range:** sample 0x008000 (+0.5) → both slots carry 0x400000 on q=1..24, zeros on q=0 and q=25..31; sat_flag stays 0.
- **Saturation:**
  - 0x020000 → 0x7FFFFF with sat_flag pulse.
  - 0xFE0000 → 0x800000 with pulse.
  - 0xFF0000 (-1.0) → 0x800000 with no pulse.
  - 0x00FFFF → 0x7FFF80 with no pulse.
- **Underrun and bypass:**
  - Skip one frame → previous word repeats, underrun pulses, sample_req still pulses.
  - Assert valid exactly on a boundary cycle with hold empty → that word is used, no underrun.
- **Backpressure:** two back-to-back valids → first captured, ready low until the next boundary, second captured the cycle after; frames carry them in order.
- **Mid-frame reset:** rst_n low at bit_cnt=40 for 1 cycle → outputs 0 next cycle, held sample discarded, stream restarts as in the reset scenario.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S transmitter at the tail of the synth datapath: takes one Q8.16 mix sample per frame,
// clips it to Q1.23 and shifts it out MSB-first on both channels with a one-bit I2S delay.
module i2s_dac_tx #(
    parameter int CLK_DIV   = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] sample_in,
    input  logic        sample_valid,
    output logic        sample_ready,
    output logic        sample_req,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        sat_flag,
    output logic        underrun
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN  = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(24);

    typedef struct packed {
        logic [23:0] word;
        logic        clipped;
    } conv_t;

    // Q8.16 -> Q1.23: in range when the integer bits are pure sign extension.
    function automatic conv_t convert(input logic [23:0] s);
        conv_t r;
        if (s[23:16] == {8{s[23]}}) begin
            r.word    = {s[16:0], 7'b0};
            r.clipped = 1'b0;
        end else begin
            r.word    = s[23] ? 24'h800000 : 24'h7FFFFF;
            r.clipped = 1'b1;
        end
        return r;
    endfunction

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [23:0]      word_q, word_d;
    logic [23:0]      hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             bclk_q, bclk_d;
    logic             lrclk_q, lrclk_d;
    logic             sdata_q, sdata_d;
    logic             sample_ready_q, sample_ready_d;
    logic             sample_req_q, sample_req_d;
    logic             sat_flag_q, sat_flag_d;
    logic             underrun_q, underrun_d;

    logic             div_last;
    logic             fall_evt;
    logic             frame_end;
    logic             capture;
    logic [BIT_W-1:0] next_bit;
    logic             next_lr;
    logic [BIT_W-1:0] slot_pos;
    logic [4:0]       bit_sel;
    conv_t            src_conv;

    always_comb begin
        // NOTE: every signal written here gets a value on every path first, so no latches form.
        div_last  = (div_cnt_q == DIV_LAST);
        fall_evt  = div_last & bclk_q;
        frame_end = fall_evt & (bit_cnt_q == BIT_LAST);
        capture   = sample_valid & sample_ready_q;

        div_cnt_d    = div_last ? '0 : div_cnt_q + 1'b1;
        bclk_d       = bclk_q ^ div_last;
        bit_cnt_d    = bit_cnt_q;
        word_d       = word_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        sample_req_d = 1'b0;
        sat_flag_d   = 1'b0;
        underrun_d   = 1'b0;

        // At a boundary the held sample wins; with hold empty a same-cycle capture bypasses.
        src_conv = convert(hold_full_q ? hold_q : sample_in);

        if (frame_end) begin
            sample_req_d = 1'b1;
            if (hold_full_q || capture) begin
                word_d      = src_conv.word;
                sat_flag_d  = src_conv.clipped;
                hold_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end else if (capture) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        next_bit = frame_end ? '0 : bit_cnt_q + 1'b1;
        next_lr  = (next_bit >= SLOT_LEN);
        slot_pos = next_lr ? next_bit - SLOT_LEN : next_bit;
        bit_sel  = 5'(DATA_BITS - slot_pos);

        // Serial outputs move only on bclk falling so the DAC samples them on a settled rise.
        if (fall_evt) begin
            bit_cnt_d = next_bit;
            lrclk_d   = next_lr;
            sdata_d   = (slot_pos != '0 && slot_pos <= DATA_BITS) ? word_d[bit_sel] : 1'b0;
        end

        sample_ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            div_cnt_q      <= '0;
            bit_cnt_q      <= '0;
            word_q         <= '0;
            hold_full_q    <= 1'b0;
            bclk_q         <= 1'b0;
            lrclk_q        <= 1'b0;
            sdata_q        <= 1'b0;
            sample_ready_q <= 1'b0;
            sample_req_q   <= 1'b0;
            sat_flag_q     <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            word_q         <= word_d;
            hold_full_q    <= hold_full_d;
            bclk_q         <= bclk_d;
            lrclk_q        <= lrclk_d;
            sdata_q        <= sdata_d;
            sample_ready_q <= sample_ready_d;
            sample_req_q   <= sample_req_d;
            sat_flag_q     <= sat_flag_d;
            underrun_q     <= underrun_d;
        end
    end

    // NOTE: the hold data needs no reset; hold_full_q alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    assign sample_ready = sample_ready_q;
    assign sample_req   = sample_req_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign sat_flag     = sat_flag_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: a cycle monitor checks the I2S stream, pulses and ready every clock
// against a scoreboard of expected frame words; scenario tasks check the called-out cases.
module tb_i2s_dac_tx;
    localparam int CD    = 2;
    localparam int SB    = 32;
    localparam int FRAME = 4 * CD * SB;

    typedef struct {
        logic [23:0] word;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun;

    int vectors = 0;
    int miscompares = 0;

    int          n = -1;
    logic [23:0] exp_word = '0;
    exp_t        sb_q[$];
    logic [23:0] rx_shift = '0;
    logic [23:0] rx_left = 'x, rx_right = 'x;
    logic [23:0] frame_left = 'x, frame_right = 'x;

    exp_t m_e;
    int   m_bit, m_q;
    logic m_bclk, m_lr, m_sd, m_req, m_sat, m_und, m_rdy;

    i2s_dac_tx #(.CLK_DIV(CD), .SLOT_BITS(SB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_req  (sample_req),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .sat_flag    (sat_flag),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // n counts edges since reset release (0 = first edge with rst_n high).
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            n = -1;
            exp_word = '0;
            sb_q.delete();
            rx_shift = '0;
            rx_left = 'x; rx_right = 'x; frame_left = 'x; frame_right = 'x;
            vectors++;
            if ({sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun} !== 7'b0) begin
                miscompares++;
                $display("FAIL mon_reset_outputs: got %b want 0000000",
                         {sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun});
            end
        end else begin
            n++;
            m_req = 1'b0; m_sat = 1'b0; m_und = 1'b0;
            if (((n + 1) % FRAME) == 0) begin
                m_req = 1'b1;
                frame_left = rx_left; frame_right = rx_right;
                rx_left = 'x; rx_right = 'x;
                if (sb_q.size() != 0) begin
                    m_e = sb_q.pop_front();
                    exp_word = m_e.word;
                    m_sat = m_e.sat;
                end else begin
                    m_und = 1'b1;
                end
            end
            m_bit  = ((n + 1) / (2 * CD)) % (2 * SB);
            m_q    = m_bit % SB;
            m_bclk = 1'(((n + 1) / CD) % 2);
            m_lr   = (m_bit >= SB);
            m_sd   = (m_q >= 1 && m_q <= 24) ? exp_word[5'(24 - m_q)] : 1'b0;
            m_rdy  = (sb_q.size() == 0);
            if (((n + 1) % (2 * CD)) == CD) begin
                if (m_q >= 1 && m_q <= 24) rx_shift = {rx_shift[22:0], sdata};
                if (m_q == 24) begin
                    if (m_lr) rx_right = rx_shift;
                    else      rx_left  = rx_shift;
                end
            end
            vectors++;
            if ({bclk, lrclk, sdata} !== {m_bclk, m_lr, m_sd}) begin
                miscompares++;
                $display("FAIL mon_stream n=%0d: got bclk/lrclk/sdata %b want %b",
                         n, {bclk, lrclk, sdata}, {m_bclk, m_lr, m_sd});
            end
            vectors++;
            if ({sample_req, sat_flag, underrun} !== {m_req, m_sat, m_und}) begin
                miscompares++;
                $display("FAIL mon_pulses n=%0d: got req/sat/und %b want %b",
                         n, {sample_req, sat_flag, underrun}, {m_req, m_sat, m_und});
            end
            vectors++;
            if (sample_ready !== m_rdy) begin
                miscompares++;
                $display("FAIL mon_ready n=%0d: got %b want %b", n, sample_ready, m_rdy);
            end
        end
    end

    task automatic wait_boundary();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(n >= 0 && ((n + 1) % FRAME) == 0) && guard < 2 * FRAME);
        if (!(n >= 0 && ((n + 1) % FRAME) == 0)) begin
            vectors++; miscompares++;
            $display("FAIL boundary_timeout: n=%0d after %0d cycles", n, guard);
        end
    endtask

    task automatic send(input logic [23:0] s, input logic [23:0] w, input logic exp_sat);
        int   guard = 0;
        exp_t e;
        sample_in = s;
        sample_valid = 1'b1;
        while (sample_ready !== 1'b1 && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL send_timeout: sample %h got ready %b want 1", s, sample_ready);
        end else begin
            e.word = w;
            e.sat = exp_sat;
            sb_q.push_back(e);
            @(negedge clk);
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if ({sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_hold: got %b want 0000000",
                     {sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready_rise: got %b want 1", sample_ready);
        end
        vectors++;
        if (bclk !== 1'b0) begin
            miscompares++; $display("FAIL reset_bclk_early: got %b want 0", bclk);
        end
        @(negedge clk);
        vectors++;
        if (bclk !== 1'b1) begin
            miscompares++; $display("FAIL reset_bclk_first_rise: got %b want 1", bclk);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'h0 || frame_right !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_first_frame: got %h/%h want 000000/000000", frame_left, frame_right);
        end
    endtask

    task automatic test_in_range();
        send(24'h008000, 24'h400000, 1'b0);
        wait_boundary();
        vectors++;
        if (sat_flag !== 1'b0 || underrun !== 1'b0 || sample_req !== 1'b1) begin
            miscompares++;
            $display("FAIL in_range_load: got sat/und/req %b%b%b want 001", sat_flag, underrun, sample_req);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'h400000 || frame_right !== 24'h400000) begin
            miscompares++;
            $display("FAIL in_range_word: got %h/%h want 400000/400000", frame_left, frame_right);
        end
    endtask

    task automatic test_saturation();
        logic [23:0] ins  [4] = '{24'h020000, 24'hFE0000, 24'hFF0000, 24'h00FFFF};
        logic [23:0] outs [4] = '{24'h7FFFFF, 24'h800000, 24'h800000, 24'h7FFF80};
        logic        flags[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(ins[i], outs[i], flags[i]);
            wait_boundary();
            vectors++;
            if (sat_flag !== flags[i]) begin
                miscompares++;
                $display("FAIL sat_flag_%0d: in %h got %b want %b", i, ins[i], sat_flag, flags[i]);
            end
            wait_boundary();
            vectors++;
            if (frame_left !== outs[i] || frame_right !== outs[i]) begin
                miscompares++;
                $display("FAIL sat_word_%0d: in %h got %h/%h want %h", i, ins[i],
                         frame_left, frame_right, outs[i]);
            end
        end
    endtask

    task automatic test_underrun();
        wait_boundary();
        vectors++;
        if (underrun !== 1'b1 || sample_req !== 1'b1 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL underrun_pulse: got und/req/sat %b%b%b want 110", underrun, sample_req, sat_flag);
        end
        vectors++;
        if (frame_left !== 24'h7FFF80 || frame_right !== 24'h7FFF80) begin
            miscompares++;
            $display("FAIL underrun_repeat: got %h/%h want 7fff80", frame_left, frame_right);
        end
    endtask

    task automatic test_bypass();
        int   guard = 0;
        exp_t e;
        do begin
            @(negedge clk);
            guard++;
        end while (!(n >= 0 && ((n + 2) % FRAME) == 0) && guard < 2 * FRAME);
        vectors++;
        if (sample_ready !== 1'b1 || ((n + 2) % FRAME) != 0) begin
            miscompares++;
            $display("FAIL bypass_setup: ready %b n=%0d, want ready 1 one cycle before boundary", sample_ready, n);
        end
        sample_in = 24'hFF8000;
        sample_valid = 1'b1;
        e.word = 24'hC00000;
        e.sat = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
        vectors++;
        if (underrun !== 1'b0 || sample_req !== 1'b1 || sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_boundary: got und/req/ready %b%b%b want 011", underrun, sample_req, sample_ready);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'hC00000 || frame_right !== 24'hC00000) begin
            miscompares++;
            $display("FAIL bypass_word: got %h/%h want c00000", frame_left, frame_right);
        end
    endtask

    task automatic test_back_to_back();
        send(24'h00C000, 24'h600000, 1'b0);
        vectors++;
        if (sample_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_ready_fall: got %b want 0", sample_ready);
        end
        send(24'hFFC000, 24'hE00000, 1'b0);
        vectors++;
        if ((n % FRAME) != 0) begin
            miscompares++;
            $display("FAIL b2b_second_capture: captured at frame offset %0d want 0", n % FRAME);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'h600000 || frame_right !== 24'h600000) begin
            miscompares++;
            $display("FAIL b2b_first_word: got %h/%h want 600000", frame_left, frame_right);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'hE00000 || frame_right !== 24'hE00000) begin
            miscompares++;
            $display("FAIL b2b_second_word: got %h/%h want e00000", frame_left, frame_right);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        send(24'h020000, 24'h7FFFFF, 1'b1);
        while (!(n >= 0 && ((n + 1) / (2 * CD)) % (2 * SB) == 40) && guard < 2 * FRAME) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (((n + 1) / (2 * CD)) % (2 * SB) != 40) begin
            miscompares++; $display("FAIL mid_reset_setup: could not reach bit 40, n=%0d", n);
        end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %b want 0000000",
                     {sample_ready, sample_req, bclk, lrclk, sdata, sat_flag, underrun});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (sample_ready !== 1'b1 || bclk !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_restart: got ready/bclk %b%b want 10", sample_ready, bclk);
        end
        @(negedge clk);
        vectors++;
        if (bclk !== 1'b1) begin
            miscompares++; $display("FAIL mid_reset_bclk_rise: got %b want 1", bclk);
        end
        wait_boundary();
        vectors++;
        if (frame_left !== 24'h0 || frame_right !== 24'h0 || underrun !== 1'b1 || sat_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_dropped: got %h/%h und %b sat %b want 000000 und 1 sat 0",
                     frame_left, frame_right, underrun, sat_flag);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_in_range();
        test_saturation();
        test_underrun();
        test_bypass();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
